// File: rtl/robs_pkg.sv
// robs_pkg: shared state encoding and sizing helpers for the signed divider
package robs_pkg;
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} div_state_t;
  localparam int DEF_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on {P,Q}
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH+1:0] s, t;
  always_comb begin
    s = {p, q[WIDTH-1]};
    t = s - {2'b0, d};
    p_next = t[WIDTH+1] ? s[WIDTH:0] : t[WIDTH:0];
    q_next = {q[WIDTH-2:0], ~t[WIDTH+1]};
  end
endmodule

// File: rtl/robs_divider.sv
// robs_divider: sequential signed divider, one restoring step per clock
module robs_divider
  import robs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int CW = cnt_w(WIDTH);
  div_state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] p, p_n;
  logic [WIDTH-1:0] q, q_n, d, a;
  logic sq, sr, dz, ov;
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction
  div_step #(.WIDTH(WIDTH)) u_step (.p(p), .q(q), .d(d), .p_next(p_n), .q_next(q_n));
  always_comb begin
    nxt = st == IDLE ? (start ? ITER : IDLE)
        : st == ITER ? (cnt == CW'(1) ? FIX : ITER)
        : st == FIX  ? DONE : IDLE;
    busy = st == ITER || st == FIX;
    done = st == DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      p <= '0;
      q <= '0;
      d <= '0;
      a <= '0;
      sq <= 1'b0;
      sr <= 1'b0;
      dz <= 1'b0;
      ov <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      st <= nxt;
      if (st == IDLE && start) begin
        p <= '0;
        q <= mag(dividend);
        d <= mag(divisor);
        a <= dividend;
        sq <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        sr <= dividend[WIDTH-1];
        dz <= divisor == '0;
        ov <= dividend == {1'b1, {(WIDTH-1){1'b0}}} && divisor == '1;
        cnt <= CW'(WIDTH);
      end
      if (st == ITER) begin
        p <= p_n;
        q <= q_n;
        cnt <= cnt - CW'(1);
      end
      // a zero divisor overrides whatever the iterations produced
      if (st == FIX) begin
        quotient <= dz ? '1 : sq ? -q : q;
        remainder <= dz ? a : sr ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        div_by_zero <= dz;
        overflow <= ov;
      end
    end
  end
endmodule
